// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: branch history table of 2-bit saturating counters with a
// flush walker and a one-cycle statistics read port.
// Optional feature macro: BP_STATS_EN. When it is defined, branch, correct,
// taken and drop statistics are kept and readable. When it is undefined, no
// counters exist and rd_data always reads 0. The handshake timing is the same
// in both builds.
module bp_table_ctrl #(
  parameter int TABLE_ADR_WIDTH = 2,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic                 flush_req,
  output logic                 flush_busy,
  input  logic                 rd_req,
  input  logic [1:0]           rd_sel,
  output logic                 rd_ack,
  output logic [CNT_WIDTH-1:0] rd_data
);

  localparam int TABLE_SIZE = 2 ** TABLE_ADR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                     state_reg, state_next;
  logic [TABLE_ADR_WIDTH-1:0] walk_ptr_reg, walk_ptr_next;
  logic [1:0]                 table_q [TABLE_SIZE];

  logic [TABLE_ADR_WIDTH-1:0] pred_idx;
  logic [TABLE_ADR_WIDTH-1:0] upd_idx;
  logic                       in_flush;
  logic                       upd_en;
  logic                       rd_capture;

  // Word-aligned PCs: the low two bits never select an entry.
  assign pred_idx   = pred_pc[TABLE_ADR_WIDTH+1:2];
  assign upd_idx    = upd_pc[TABLE_ADR_WIDTH+1:2];
  assign in_flush   = (state_reg == FLUSH);
  // Updates are only accepted outside a flush; during a flush they are dropped.
  assign upd_en     = upd_valid && !in_flush;
  // Read data is captured on the IDLE->READ transition.
  assign rd_capture = (state_reg == IDLE) && !flush_req && rd_req;

  // Control FSM state and walk pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      walk_ptr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      walk_ptr_reg <= walk_ptr_next;
    end
  end

  // Next-state logic: flush has priority over a read; read lasts one cycle.
  always_comb begin
    state_next    = state_reg;
    walk_ptr_next = walk_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (flush_req) begin
          state_next    = FLUSH;
          walk_ptr_next = '0;
        end else if (rd_req) begin
          state_next = READ;
        end
      end
      FLUSH: begin
        walk_ptr_next = walk_ptr_reg + TABLE_ADR_WIDTH'(1);
        if (walk_ptr_reg == '1) begin
          state_next = IDLE;
        end
      end
      READ: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign flush_busy = in_flush;
  assign rd_ack     = (state_reg == READ);
  // The prediction reads the stored value directly, so a same-cycle update
  // to the same entry is not visible until the next cycle.
  assign pred_taken = in_flush ? 1'b0 : table_q[pred_idx][1];

  // One saturating counter per table entry.
  for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_entry
    logic [1:0] entry_reg;
    logic [1:0] entry_next;

    // Entry update: the flush walk rewrites the entry, otherwise it saturates up or down.
    always_comb begin
      entry_next = entry_reg;
      if (in_flush) begin
        if (walk_ptr_reg == TABLE_ADR_WIDTH'(gi)) begin
          entry_next = 2'b01;
        end
      end else if (upd_en && (upd_idx == TABLE_ADR_WIDTH'(gi))) begin
        if (upd_taken && (entry_reg != 2'b11)) begin
          entry_next = entry_reg + 2'd1;
        end else if (!upd_taken && (entry_reg != 2'b00)) begin
          entry_next = entry_reg - 2'd1;
        end
      end
    end

    // Entry storage; reset leaves every entry weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_reg <= 2'b01;
      end else begin
        entry_reg <= entry_next;
      end
    end

    assign table_q[gi] = entry_reg;
  end

`ifdef BP_STATS_EN
  localparam int DROP_W = CNT_WIDTH - 8;

  logic [CNT_WIDTH-1:0] branches_reg;
  logic [CNT_WIDTH-1:0] correct_reg;
  logic [CNT_WIDTH-1:0] taken_reg;
  logic [DROP_W-1:0]    drop_reg;
  logic [CNT_WIDTH-1:0] rd_data_reg;
  logic [CNT_WIDTH-1:0] rd_sel_value;
  logic                 upd_hit;

  // The stored prediction bit is compared before the entry changes.
  assign upd_hit = (table_q[upd_idx][1] == upd_taken);

  // Statistics counters. Branch, correct and taken counts wrap; the drop count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branches_reg <= '0;
      correct_reg  <= '0;
      taken_reg    <= '0;
      drop_reg     <= '0;
    end else begin
      if (upd_en) begin
        branches_reg <= branches_reg + CNT_WIDTH'(1);
        if (upd_taken) begin
          taken_reg <= taken_reg + CNT_WIDTH'(1);
        end
        if (upd_hit) begin
          correct_reg <= correct_reg + CNT_WIDTH'(1);
        end
      end
      if (upd_valid && in_flush && (drop_reg != '1)) begin
        drop_reg <= drop_reg + DROP_W'(1);
      end
    end
  end

  // Read select mux.
  always_comb begin
    rd_sel_value = '0;
    case (rd_sel)
      2'd0:    rd_sel_value = branches_reg;
      2'd1:    rd_sel_value = correct_reg;
      2'd2:    rd_sel_value = taken_reg;
      default: rd_sel_value = {drop_reg, 6'b0, in_flush, (state_reg == READ)};
    endcase
  end

  // Read data register, loaded when a read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else if (rd_capture) begin
      rd_data_reg <= rd_sel_value;
    end
  end

  assign rd_data = rd_data_reg;

  logic unused_bits;
  assign unused_bits = ^{pred_pc[31:TABLE_ADR_WIDTH+2], pred_pc[1:0],
                         upd_pc[31:TABLE_ADR_WIDTH+2], upd_pc[1:0]};
`else
  // Without statistics the read port still handshakes but returns zero.
  assign rd_data = '0;

  logic unused_bits;
  assign unused_bits = ^{pred_pc[31:TABLE_ADR_WIDTH+2], pred_pc[1:0],
                         upd_pc[31:TABLE_ADR_WIDTH+2], upd_pc[1:0],
                         rd_sel, rd_capture};
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Directed bench for bp_table_ctrl: a table of prediction/update vectors plus
// hand-written sequences for flush, read, reset abort and counter wrap.
// A second instance with CNT_WIDTH=9 shares all inputs to observe counter
// wrap and drop-count saturation.
module tb_bp_table_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        flush_req;
  logic        rd_req;
  logic [1:0]  rd_sel;

  logic        pred_taken, flush_busy, rd_ack;
  logic [31:0] rd_data;
  logic        pred_taken_n, flush_busy_n, rd_ack_n;
  logic [8:0]  rd_data_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_table_ctrl #(.TABLE_ADR_WIDTH(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .flush_req(flush_req), .flush_busy(flush_busy), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data)
  );

  bp_table_ctrl #(.TABLE_ADR_WIDTH(2), .CNT_WIDTH(9)) dut_n (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken_n),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .flush_req(flush_req), .flush_busy(flush_busy_n), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_ack(rd_ack_n), .rd_data(rd_data_n)
  );

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] ppc;
    logic        exp_pred;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] ppc,
                              input logic ep);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.ppc = ppc; v.exp_pred = ep;
    return v;
  endfunction

  // Expected statistics value, zero when the statistics build is off.
  function automatic logic [31:0] sx(input logic [31:0] v);
`ifdef BP_STATS_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Apply one vector: drive, check the pre-update prediction, clock it in.
  task automatic run_vec(input int i);
    @(negedge clk);
    upd_valid = vecs[i].uv;
    upd_pc    = vecs[i].upc;
    upd_taken = vecs[i].ut;
    pred_pc   = vecs[i].ppc;
    #1;
    check($sformatf("vec%0d pred", i), {31'b0, pred_taken}, {31'b0, vecs[i].exp_pred});
    @(posedge clk);
  endtask

  // One statistics read from IDLE; rd_ack must follow one cycle after rd_req.
  task automatic do_read(input logic [1:0] sel, input logic [31:0] exp_w,
                         input logic [31:0] exp_n, input string name);
    @(negedge clk);
    upd_valid = 1'b0;
    rd_req    = 1'b1;
    rd_sel    = sel;
    @(negedge clk);
    check({name, " ack"}, {31'b0, rd_ack}, 32'd1);
    check({name, " ack_n"}, {31'b0, rd_ack_n}, 32'd1);
    check({name, " data"}, rd_data, exp_w);
    check({name, " data_n"}, {23'b0, rd_data_n}, exp_n);
    rd_req = 1'b0;
    @(negedge clk);
    check({name, " ack_low"}, {31'b0, rd_ack}, 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int last_busy;
    int ack_cyc;

    // Vector table: entry 2 (pc 0x8) walks up, saturates, walks down, saturates.
    vecs[0]  = mk(1, 32'h8,  1, 32'h8,  0);
    vecs[1]  = mk(1, 32'h8,  1, 32'h8,  1);
    vecs[2]  = mk(1, 32'h8,  1, 32'h8,  1);
    vecs[3]  = mk(0, 32'h0,  0, 32'h8,  1);
    vecs[4]  = mk(1, 32'h8,  0, 32'h8,  1);
    vecs[5]  = mk(1, 32'h8,  0, 32'h8,  1);
    vecs[6]  = mk(1, 32'h8,  0, 32'h8,  0);
    vecs[7]  = mk(1, 32'h8,  0, 32'h8,  0);
    vecs[8]  = mk(0, 32'h0,  0, 32'h8,  0);
    vecs[9]  = mk(1, 32'hC,  1, 32'h4,  0);
    vecs[10] = mk(1, 32'hC,  1, 32'hC,  1);
    vecs[11] = mk(1, 32'h1C, 0, 32'h1C, 1);
    vecs[12] = mk(0, 32'h0,  0, 32'hC,  1);
    // After flush: each entry must be 01 (pred 0, then 1 after one taken update).
    vecs[13] = mk(1, 32'h0,  1, 32'h0,  0);
    vecs[14] = mk(0, 32'h0,  0, 32'h0,  1);
    vecs[15] = mk(1, 32'h4,  1, 32'h4,  0);
    vecs[16] = mk(0, 32'h0,  0, 32'h4,  1);
    vecs[17] = mk(1, 32'h8,  1, 32'h8,  0);
    vecs[18] = mk(0, 32'h0,  0, 32'h8,  1);
    vecs[19] = mk(1, 32'hC,  1, 32'hC,  0);
    vecs[20] = mk(0, 32'h0,  0, 32'hC,  1);
    // After a reset mid-flush: entry 3 back to 01.
    vecs[21] = mk(0, 32'h0,  0, 32'hC,  0);

    rst = 1'b1; pred_pc = 32'h8; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    flush_req = 1'b0; rd_req = 1'b0; rd_sel = 2'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", {31'b0, flush_busy}, 32'd0);
    check("rst ack", {31'b0, rd_ack}, 32'd0);
    check("rst data", rd_data, 32'd0);
    check("rst pred", {31'b0, pred_taken}, 32'd0);
    rst = 1'b0;

    // Three taken updates at 0x8
    for (int i = 0; i <= 2; i++) run_vec(i);
    do_read(2'd0, sx(32'd3), sx(32'd3), "branches3");
    do_read(2'd2, sx(32'd3), sx(32'd3), "taken3");
    do_read(2'd1, sx(32'd2), sx(32'd2), "correct2");
    do_read(2'd3, sx(32'd0), sx(32'd0), "status0");

    // Saturation down, aliasing, other entries
    for (int i = 3; i <= 12; i++) run_vec(i);
    do_read(2'd0, sx(32'd10), sx(32'd10), "branches10");
    do_read(2'd2, sx(32'd5), sx(32'd5), "taken5");
    do_read(2'd1, sx(32'd5), sx(32'd5), "correct5");

    // Flush with a retrigger and two dropped updates at entry 0
    @(negedge clk);
    pred_pc   = 32'hC;
    #1;
    check("pre-flush pred", {31'b0, pred_taken}, 32'd1);
    flush_req = 1'b1;
    busy_cnt  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      flush_req = 1'b0;
      upd_valid = 1'b0;
      if (flush_busy) begin
        busy_cnt++;
        check($sformatf("flush pred c%0d", busy_cnt), {31'b0, pred_taken}, 32'd0);
        if (busy_cnt == 2) flush_req = 1'b1;
        if (busy_cnt >= 3) begin
          upd_valid = 1'b1; upd_pc = 32'h0; upd_taken = 1'b1;
        end
      end
    end
    check("flush busy cycles", busy_cnt, 32'd4);
    check("flush busy end", {31'b0, flush_busy}, 32'd0);
    for (int i = 13; i <= 20; i++) run_vec(i);
    do_read(2'd3, sx(32'h200), sx(32'h100), "status drop2");
    do_read(2'd0, sx(32'd14), sx(32'd14), "branches14");

    // Simultaneous flush_req and rd_req: flush first, then read
    @(negedge clk);
    upd_valid = 1'b0; flush_req = 1'b1; rd_req = 1'b1; rd_sel = 2'd0;
    busy_cnt = 0; last_busy = -100; ack_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (flush_busy) begin
        busy_cnt++;
        last_busy = c;
      end
      if (rd_ack) begin
        ack_cyc = c;
        break;
      end
    end
    check("flush+rd busy cycles", busy_cnt, 32'd4);
    check("flush+rd ack delay", ack_cyc - last_busy, 32'd2);
    check("flush+rd data", rd_data, sx(32'd14));
    rd_req = 1'b0;
    @(negedge clk);
    check("flush+rd ack low", {31'b0, rd_ack}, 32'd0);

    // Reset in the middle of a flush with a read pending
    flush_req = 1'b1; rd_req = 1'b1; rd_sel = 2'd0; pred_pc = 32'hC;
    @(negedge clk);
    flush_req = 1'b0;
    @(negedge clk);
    check("abort busy before", {31'b0, flush_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort busy", {31'b0, flush_busy}, 32'd0);
    check("abort pred", {31'b0, pred_taken}, 32'd0);
    check("abort data", rd_data, 32'd0);
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack_cyc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rd_ack || flush_busy) ack_cyc++;
    end
    check("abort no pending", ack_cyc, 32'd0);
    run_vec(21);
    do_read(2'd0, 32'd0, 32'd0, "branches after rst");

    // 512 updates: 32-bit count reads 512, 9-bit count wraps to 0
    @(negedge clk);
    for (int i = 0; i < 512; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h4; upd_taken = i[0];
      @(negedge clk);
    end
    upd_valid = 1'b0;
    do_read(2'd0, sx(32'd512), 32'd0, "branches wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
